// File: rtl/frame_integrator.sv
// frame_integrator: integrates a stream of difference samples over frames of
// ACC_LEN valid samples. It emits one registered frame sum per frame with a
// sticky overflow flag. The sum either saturates or wraps.
module frame_integrator #(
    parameter int    DIN_WIDTH     = 5,
    parameter string DIN_IS_SIGNED = "TRUE",
    parameter int    ACC_WIDTH     = 8,
    parameter int    ACC_LEN       = 4,
    parameter string SATURATE      = "TRUE"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_vld,
    input  logic                 sync,
    output logic [ACC_WIDTH-1:0] dout,
    output logic                 dout_vld,
    output logic                 dout_ovf
);

    localparam bit IS_SIGNED = (DIN_IS_SIGNED == "TRUE");
    localparam bit DO_SAT    = (SATURATE == "TRUE");
    localparam int CNT_W     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    localparam logic [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(1) << (ACC_WIDTH - 1);
    localparam logic [ACC_WIDTH-1:0] S_MAX = ~S_MIN;
    localparam logic [ACC_WIDTH-1:0] U_MAX = '1;
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(ACC_LEN - 1);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    // One accumulate step at ACC_WIDTH+1 bits. It returns {ovf, result}, and
    // the result is clamped to the range limits when saturation is enabled.
    function automatic logic [ACC_WIDTH:0] add_clamp(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0]   sum;
        logic                 ovf;
        logic [ACC_WIDTH-1:0] res;
        if (IS_SIGNED) begin
            sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
            ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
            res = (ovf && DO_SAT) ? (sum[ACC_WIDTH] ? S_MIN : S_MAX) : sum[ACC_WIDTH-1:0];
        end else begin
            sum = {1'b0, a} + {1'b0, b};
            ovf = sum[ACC_WIDTH];
            res = (ovf && DO_SAT) ? U_MAX : sum[ACC_WIDTH-1:0];
        end
        return {ovf, res};
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] r_dout;
    logic                 r_dout_vld;
    logic                 r_dout_ovf;

    logic [ACC_WIDTH-1:0] w_din_ext;
    logic [ACC_WIDTH-1:0] w_add_res;
    logic                 w_add_ovf;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_ovf_nxt;
    logic                 w_dump;
    logic [ACC_WIDTH-1:0] w_dump_val;
    logic                 w_dump_ovf;

    // Extend din to accumulator width: sign bit replicated only in signed mode.
    always_comb begin
        w_din_ext                  = {ACC_WIDTH{IS_SIGNED & din[DIN_WIDTH-1]}};
        w_din_ext[DIN_WIDTH-1:0]   = din;
    end

    // Next-state and next-accumulator logic. sync overrides everything else.
    // A sync with a sample starts a frame at count 1, and that sample alone
    // completes the frame when ACC_LEN is 1.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_dump      = 1'b0;
        w_dump_val  = r_acc;
        w_dump_ovf  = r_ovf;
        {w_add_ovf, w_add_res} = add_clamp(r_acc, w_din_ext);
        if (sync) begin
            w_state_nxt = S_ACCUM;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            if (din_vld) begin
                if (ACC_LEN == 1) begin
                    w_dump     = 1'b1;
                    w_dump_val = w_din_ext;
                    w_dump_ovf = 1'b0;
                end else begin
                    w_acc_nxt = w_din_ext;
                    w_cnt_nxt = CNT_W'(1);
                end
            end
        end else if (r_state == S_ACCUM && din_vld) begin
            if (r_cnt == LAST) begin
                w_dump     = 1'b1;
                w_dump_val = w_add_res;
                w_dump_ovf = r_ovf | w_add_ovf;
                w_acc_nxt  = '0;
                w_cnt_nxt  = '0;
                w_ovf_nxt  = 1'b0;
            end else begin
                w_acc_nxt = w_add_res;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                w_ovf_nxt = r_ovf | w_add_ovf;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Accumulator, frame counter and output registers. The frame sum is held between dumps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_dout_ovf <= 1'b0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
            r_dout_vld <= w_dump;
            if (w_dump) begin
                r_dout     <= w_dump_val;
                r_dout_ovf <= w_dump_ovf;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign dout_ovf = r_dout_ovf;

endmodule

// File: doc/frame_integrator.md
# frame_integrator

- Sequential accumulator that is the inverse of the team's differencing subtractor.
- Sums a stream of signed or unsigned difference samples over frames of `ACC_LEN` valid samples, reconstructing the running total.
- Emits one registered frame sum per frame, with an overflow flag.
- Sits downstream of differencing/decimation stages, ahead of packetisation.

## Interface

Parameters:
- `DIN_WIDTH`, 5: width of input sample.
- `DIN_IS_SIGNED`, "TRUE": "TRUE" sign-extends `din`; "FALSE" zero-extends it.
- `ACC_WIDTH`, 8: accumulator and output width. Must be ≥ `DIN_WIDTH`.
- `ACC_LEN`, 4: valid samples per frame. Must be ≥ 1.
- `SATURATE`, "TRUE": "TRUE" clamps at the range limits; "FALSE" wraps modulo 2^`ACC_WIDTH`.

Ports:
- `clk` input, 1: single clock; all logic on its rising edge.
- `rst_n` input, 1: reset is synchronous and active-low.
- `din` input, `DIN_WIDTH`: sample to accumulate.
- `din_vld` input, 1: `din` is valid this cycle.
- `sync` input, 1: frame-alignment pulse. Starts a new frame.
- `dout` output, `ACC_WIDTH`: frame sum. Held until the next dump.
- `dout_vld` output, 1: one-cycle pulse when `dout` is updated.
- `dout_ovf` output, 1: overflow/wrap occurred in the frame now on `dout`.

## Operation

States:
- IDLE, entered on reset: ignores `din_vld` until `sync`.
- ACCUM.

Transitions and rules:
- **`sync` in any state:** go to ACCUM; the partial frame is discarded with no dump.
  - `sync` with `din_vld`: acc = ext(`din`), cnt = 1, ovf = 0.
  - `sync` alone: acc = 0, cnt = 0, ovf = 0.
- **ACCUM, `din_vld` without `sync`:** acc = acc + ext(`din`), cnt = cnt + 1.
- **`din_vld` low:** acc and cnt hold. Gaps are allowed anywhere in a frame.
- **Dump:** on the cycle the `ACC_LEN`-th valid sample is accepted (cnt reaches `ACC_LEN`):
  - `dout` <= acc + ext(`din`), after saturation/wrap.
  - `dout_ovf` <= frame ovf, including this add.
  - `dout_vld` <= 1.
  - acc <= 0, cnt <= 0, ovf <= 0.
  - Stay in ACCUM. The next valid sample, even on the very next cycle, is sample 1 of the next frame; frames run back-to-back without further `sync`.
- **`ACC_LEN` = 1:** every valid sample dumps, as `dout` = ext(`din`).
- **Simultaneous `sync` and would-be last sample:** `sync` wins. No dump; `din` becomes sample 1.
- **Extension:** `din` is extended to `ACC_WIDTH` per `DIN_IS_SIGNED`. The add is computed at `ACC_WIDTH`+1 bits.
- **Range:**
  - Signed: [-2^(`ACC_WIDTH`-1), 2^(`ACC_WIDTH`-1)-1].
  - Unsigned: [0, 2^`ACC_WIDTH`-1].
- **Saturation, per add:**
  - Out of range → clamp to the nearest limit and set ovf.
  - Later adds continue from the clamped value. E.g. at max, adding -3 gives max-3.
- **Wrap mode:** the result is truncated to `ACC_WIDTH` bits. ovf is set whenever truncation changed the value.
- **ovf** is sticky within a frame and clears at frame start.

## Timing

- Reset (`rst_n` low at a rising edge):
  - State IDLE; acc = 0, cnt = 0, ovf = 0.
  - `dout` = 0, `dout_vld` = 0, `dout_ovf` = 0.
  - Applies mid-frame too: the partial frame is lost.
- **Latency:** `dout`/`dout_vld`/`dout_ovf` are valid exactly 1 cycle after the edge that accepts the last sample.
- `dout_vld` is high for exactly 1 cycle per completed frame. `dout` and `dout_ovf` hold between dumps.
- **Throughput:** one sample per cycle, sustained, including across frame boundaries. No backpressure.
- Inputs are sampled only on rising `clk` edges; there are no combinational paths from inputs to outputs.

## Test plan

Defaults unless stated.

- Reset, then `din_vld` with values 1,1,1,1,1 and no `sync` → `dout_vld` never asserts; `dout`=0, `dout_ovf`=0.
- `sync`+`din`=3, then 5, -2, 1 on consecutive cycles → `dout_vld` one cycle after the 4th sample, `dout`=7, `dout_ovf`=0. Repeat the same four samples immediately without `sync` → second dump, `dout`=7.
- Same four values with 2 idle cycles between each → identical result (`dout`=7), dump 1 cycle after the last valid sample.
- `ACC_WIDTH`=6, `SATURATE`="TRUE":
  - Samples 15,15,15,15 → `dout`=31, `dout_ovf`=1.
  - Next frame 1,1,1,1 → `dout`=4, `dout_ovf`=0.
  - `SATURATE`="FALSE", samples 15,15,15,15 → `dout`=-4 (60 mod 64), `dout_ovf`=1.
- Mid-frame `sync`: samples 3,5 accepted, then `sync`+2, then 2,2,2 → single dump with `dout`=8. No dump for the discarded 3,5.
- Mid-frame reset: 3 samples accepted, `rst_n` low 1 cycle → all outputs 0. Samples are then ignored until `sync`, and the next dump reflects only post-`sync` data.
